// File: rtl/ysyx_24100005_pkg.sv
// Shared constants for the load/store path: funct3 codes, LSU FSM encoding,
// core-side opcodes, and the op legality check used at request accept.
package ysyx_24100005_pkg;

  // Load funct3 codes; the store codes share the B/H/W encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Major opcodes for the core-side decoder.
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // LSU FSM encoding.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  // True when funct3 is defined for the direction and the address is
  // naturally aligned for the access size.
  function automatic logic lsu_op_legal(input logic       wen,
                                        input logic [2:0] funct3,
                                        input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_LB:   ok = 1'b1;
      F3_LH:   ok = ~off[0];
      F3_LW:   ok = (off == 2'b00);
      F3_LBU:  ok = ~wen;
      F3_LHU:  ok = ~wen & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ysyx_24100005_lsu_align.sv
// Byte-lane steering: store data shift and strobe generation, plus load
// byte/half extraction with sign or zero extension. Purely combinational.
module ysyx_24100005_lsu_align
  import ysyx_24100005_pkg::*;
(
  input  logic        wen_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] st_data_o,
  output logic [3:0]  st_mask_o,
  output logic [31:0] ld_data_o
);

  logic [4:0]  sh_amt;
  logic [31:0] ld_sh;

  assign sh_amt = {off_i, 3'b000};
  assign ld_sh  = ld_word_i >> sh_amt;

  // Lane shift/strobe for stores and extract/extend for loads; strobes and
  // store data are forced to zero for loads.
  always_comb begin
    st_data_o = '0;
    st_mask_o = '0;
    ld_data_o = '0;
    case (funct3_i)
      F3_LB: begin
        st_data_o = {24'h0, st_data_i[7:0]} << sh_amt;
        st_mask_o = 4'b0001 << off_i;
        ld_data_o = {{24{ld_sh[7]}}, ld_sh[7:0]};
      end
      F3_LH: begin
        st_data_o = {16'h0, st_data_i[15:0]} << sh_amt;
        st_mask_o = 4'b0011 << off_i;
        ld_data_o = {{16{ld_sh[15]}}, ld_sh[15:0]};
      end
      F3_LW: begin
        st_data_o = st_data_i;
        st_mask_o = 4'b1111;
        ld_data_o = ld_sh;
      end
      F3_LBU:  ld_data_o = {24'h0, ld_sh[7:0]};
      F3_LHU:  ld_data_o = {16'h0, ld_sh[15:0]};
      default: ;
    endcase
    if (!wen_i) begin
      st_data_o = '0;
      st_mask_o = '0;
    end
  end

endmodule

// File: rtl/ysyx_24100005_lsu.sv
// Multi-cycle load/store unit: accepts one op, issues a word-aligned
// valid/ready memory request, waits for the response (with timeout), and
// returns an extended result over a valid/ready response channel.
module ysyx_24100005_lsu
  import ysyx_24100005_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  logic [1:0]    state_q, state_d;
  logic          wen_q, wen_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_valid_q, mem_valid_d;
  logic          mem_wen_q, mem_wen_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_wmask_q, mem_wmask_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;

  logic          in_idle;
  logic          al_wen;
  logic [2:0]    al_f3;
  logic [1:0]    al_off;
  logic [31:0]   al_st_data;
  logic [3:0]    al_st_mask;
  logic [31:0]   al_ld_data;

  assign in_idle   = (state_q == S_IDLE);
  assign req_ready = in_idle && !rst;

  // One aligner serves both directions: request fields drive it in IDLE
  // (store shaping), latched fields drive it afterwards (load extraction).
  assign al_wen = in_idle ? req_wen       : wen_q;
  assign al_f3  = in_idle ? req_funct3    : f3_q;
  assign al_off = in_idle ? req_addr[1:0] : off_q;

  ysyx_24100005_lsu_align u_align (
    .wen_i     (al_wen),
    .funct3_i  (al_f3),
    .off_i     (al_off),
    .st_data_i (req_wdata),
    .ld_word_i (mem_rsp_rdata),
    .st_data_o (al_st_data),
    .st_mask_o (al_st_mask),
    .ld_data_o (al_ld_data)
  );

  // Next-state and next-output logic for the IDLE/REQ/WAIT/RESP sequence.
  always_comb begin
    state_d      = state_q;
    wen_d        = wen_q;
    f3_d         = f3_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    mem_valid_d  = mem_valid_q;
    mem_wen_d    = mem_wen_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wmask_d  = mem_wmask_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          wen_d = req_wen;
          f3_d  = req_funct3;
          off_d = req_addr[1:0];
          if (!lsu_op_legal(req_wen, req_funct3, req_addr[1:0])) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d     = S_REQ;
            mem_valid_d = 1'b1;
            mem_wen_d   = req_wen;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_wdata_d = al_st_data;
            mem_wmask_d = al_st_mask;
          end
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          state_d     = S_WAIT;
          mem_valid_d = 1'b0;
          cnt_d       = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_rsp_valid) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = wen_q ? '0 : al_ld_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wen_q        <= 1'b0;
      f3_q         <= '0;
      off_q        <= '0;
      cnt_q        <= '0;
      mem_valid_q  <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wen_q        <= wen_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
      mem_valid_q  <= mem_valid_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign mem_valid  = mem_valid_q;
  assign mem_wen    = mem_wen_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wmask  = mem_wmask_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Directed bench for the LSU: a table of single ops run against a zero-wait
// memory, then hand-written timeout, backpressure and reset sequences.
module tb_ysyx_24100005_lsu;
  import ysyx_24100005_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_valid, mem_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  ysyx_24100005_lsu #(.TIMEOUT_CYC(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wen       (req_wen),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata)
  );

  typedef struct {
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] word;
    logic        err;
    logic [31:0] m_wdata;
    logic [3:0]  m_mask;
    logic [31:0] rdata;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic wen, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_wen    = wen;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
  endtask

  // One op with zero-wait memory: accept at cycle 0, mem_valid in cycle 1,
  // response pulse in cycle 2, resp_valid in cycle 3 (cycle 1 on errors).
  task automatic apply(input int idx);
    vec_t v;
    v = vecs[idx];
    drive_req(v.wen, v.f3, v.addr, v.wdata);
    chk($sformatf("v%0d.req_ready", idx), {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    if (v.err) begin
      chk($sformatf("v%0d.err_mem_valid", idx), {31'b0, mem_valid}, 32'd0);
      chk($sformatf("v%0d.err_resp_valid", idx), {31'b0, resp_valid}, 32'd1);
      chk($sformatf("v%0d.err_resp_err", idx), {31'b0, resp_err}, 32'd1);
      chk($sformatf("v%0d.err_rdata", idx), resp_rdata, 32'd0);
    end else begin
      chk($sformatf("v%0d.mem_valid", idx), {31'b0, mem_valid}, 32'd1);
      chk($sformatf("v%0d.mem_addr", idx), mem_addr, {v.addr[31:2], 2'b00});
      chk($sformatf("v%0d.mem_wen", idx), {31'b0, mem_wen}, {31'b0, v.wen});
      chk($sformatf("v%0d.mem_wmask", idx), {28'b0, mem_wmask}, {28'b0, v.m_mask});
      if (v.wen) chk($sformatf("v%0d.mem_wdata", idx), mem_wdata, v.m_wdata);
      chk($sformatf("v%0d.early_resp", idx), {31'b0, resp_valid}, 32'd0);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk($sformatf("v%0d.mem_valid_drop", idx), {31'b0, mem_valid}, 32'd0);
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = v.word;
      tick();
      mem_rsp_valid = 1'b0;
      chk($sformatf("v%0d.resp_valid", idx), {31'b0, resp_valid}, 32'd1);
      chk($sformatf("v%0d.rdata", idx), resp_rdata, v.rdata);
      chk($sformatf("v%0d.resp_err", idx), {31'b0, resp_err}, 32'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk($sformatf("v%0d.resp_done", idx), {31'b0, resp_valid}, 32'd0);
    chk($sformatf("v%0d.ready_again", idx), {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    //            wen   f3      addr          wdata         mem word      err   m_wdata       mask     rdata
    vecs[0]  = '{1'b0, F3_LB,  32'h80000003, 32'h00000000, 32'h80FF1234, 1'b0, 32'h00000000, 4'b0000, 32'hFFFFFF80};
    vecs[1]  = '{1'b0, F3_LHU, 32'h80000002, 32'h00000000, 32'hBEEF0011, 1'b0, 32'h00000000, 4'b0000, 32'h0000BEEF};
    vecs[2]  = '{1'b0, F3_LH,  32'h80000002, 32'h00000000, 32'hBEEF0011, 1'b0, 32'h00000000, 4'b0000, 32'hFFFFBEEF};
    vecs[3]  = '{1'b1, F3_SH,  32'h80000002, 32'h1234ABCD, 32'h55555555, 1'b0, 32'hABCD0000, 4'b1100, 32'h00000000};
    vecs[4]  = '{1'b0, F3_LW,  32'h80000001, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 4'b0000, 32'h00000000};
    vecs[5]  = '{1'b0, 3'b011, 32'h80000000, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 4'b0000, 32'h00000000};
    vecs[6]  = '{1'b1, F3_SB,  32'h10000001, 32'h000000A5, 32'hFFFFFFFF, 1'b0, 32'h0000A500, 4'b0010, 32'h00000000};
    vecs[7]  = '{1'b1, F3_SW,  32'h10000004, 32'hDEADBEEF, 32'h12345678, 1'b0, 32'hDEADBEEF, 4'b1111, 32'h00000000};
    vecs[8]  = '{1'b0, F3_LBU, 32'h10000002, 32'h00000000, 32'h11F23344, 1'b0, 32'h00000000, 4'b0000, 32'h000000F2};
    vecs[9]  = '{1'b0, F3_LB,  32'h10000000, 32'h00000000, 32'h0000007F, 1'b0, 32'h00000000, 4'b0000, 32'h0000007F};
    vecs[10] = '{1'b0, F3_LW,  32'h20000008, 32'h00000000, 32'hCAFEF00D, 1'b0, 32'h00000000, 4'b0000, 32'hCAFEF00D};
    vecs[11] = '{1'b1, F3_SW,  32'h20000002, 32'h11223344, 32'h00000000, 1'b1, 32'h00000000, 4'b0000, 32'h00000000};
    vecs[12] = '{1'b1, F3_SH,  32'h20000001, 32'h11223344, 32'h00000000, 1'b1, 32'h00000000, 4'b0000, 32'h00000000};
    vecs[13] = '{1'b1, F3_LBU, 32'h20000000, 32'h11223344, 32'h00000000, 1'b1, 32'h00000000, 4'b0000, 32'h00000000};
    vecs[14] = '{1'b0, F3_LH,  32'h20000000, 32'h00000000, 32'h00008001, 1'b0, 32'h00000000, 4'b0000, 32'hFFFF8001};

    rst = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0; mem_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    tick();
    tick();
    chk("rst.req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst.mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_wmask", {28'b0, mem_wmask}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst.release_ready", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < NV; i++) apply(i);

    // Timeout: memory accepts a store but never responds.
    drive_req(1'b1, F3_SW, 32'h30000000, 32'h01020304);
    tick();
    req_valid = 1'b0;
    chk("to.mem_valid", {31'b0, mem_valid}, 32'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("to.not_yet", {31'b0, resp_valid}, 32'd0);
    tick();
    chk("to.resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("to.resp_err", {31'b0, resp_err}, 32'd1);
    chk("to.rdata", resp_rdata, 32'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hFFFFFFFF;
    tick();
    mem_rsp_valid = 1'b0;
    chk("to.late_in_resp_err", {31'b0, resp_err}, 32'd1);
    chk("to.late_in_resp_rdata", resp_rdata, 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    tick();
    mem_rsp_valid = 1'b0;
    chk("to.late_idle_resp", {31'b0, resp_valid}, 32'd0);
    chk("to.late_idle_ready", {31'b0, req_ready}, 32'd1);
    apply(0);

    // Backpressure on both the memory request and the response.
    drive_req(1'b0, F3_LW, 32'h40000010, 32'h0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp.mem_valid%0d", i), {31'b0, mem_valid}, 32'd1);
      chk($sformatf("bp.mem_addr%0d", i), mem_addr, 32'h40000010);
      chk($sformatf("bp.mem_wen%0d", i), {31'b0, mem_wen}, 32'd0);
      tick();
    end
    chk("bp.still_valid", {31'b0, mem_valid}, 32'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h89ABCDEF;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp.resp_valid%0d", i), {31'b0, resp_valid}, 32'd1);
      chk($sformatf("bp.rdata%0d", i), resp_rdata, 32'h89ABCDEF);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("bp.resp_done", {31'b0, resp_valid}, 32'd0);

    // Reset while a store request is outstanding.
    drive_req(1'b1, F3_SW, 32'h50000000, 32'h11111111);
    tick();
    req_valid = 1'b0;
    chk("rr.in_req", {31'b0, mem_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rr.mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rr.mem_wen", {31'b0, mem_wen}, 32'd0);
    chk("rr.mem_addr", mem_addr, 32'd0);
    chk("rr.mem_wdata", mem_wdata, 32'd0);
    chk("rr.mem_wmask", {28'b0, mem_wmask}, 32'd0);
    chk("rr.resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rr.req_ready", {31'b0, req_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rr.ready_after", {31'b0, req_ready}, 32'd1);
    mem_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr.no_resp%0d", i), {31'b0, resp_valid}, 32'd0);
      chk($sformatf("rr.no_mem%0d", i), {31'b0, mem_valid}, 32'd0);
    end
    mem_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    apply(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_24100005_lsu.md
Name: ysyx_24100005_lsu

Overview:
Multi-cycle load/store unit downstream of the execute adder. It takes one memory op per request: effective address, funct3, store data. It drives a word-aligned valid/ready memory port, aligns store data and generates byte masks, and extracts and sign- or zero-extends load data. It returns a write-back result to the core over a valid/ready response channel. It replaces the combinational DPI memory access in the single-cycle core with a handshaked path usable by a later bus/SRAM model.

Parameters:
TIMEOUT_CYC, 255, max cycles spent in WAIT before aborting with resp_err=1 (must be >=1; counter width clog2(TIMEOUT_CYC+1))

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  core presents an op
req_ready  output  1  LSU can accept (IDLE and rst low)
req_wen  input  1  1=store, 0=load
req_funct3  input  3  RV32 load/store funct3
req_addr  input  32  effective address (byte)
req_wdata  input  32  rs2 value for stores
resp_valid  output  1  result available
resp_ready  input  1  core consumes result
resp_rdata  output  32  extended load data; 0 for stores/errors
resp_err  output  1  misaligned, illegal funct3, or timeout
mem_valid  output  1  memory request valid
mem_ready  input  1  memory accepts request
mem_wen  output  1  write request
mem_addr  output  32  {req_addr[31:2],2'b00}
mem_wdata  output  32  lane-shifted store data
mem_wmask  output  4  byte strobes, 0 for loads
mem_rsp_valid  input  1  memory response (loads and stores), 1-cycle pulse
mem_rsp_rdata  input  32  raw aligned word

Behaviour:
- Reset (async): state=IDLE; req_ready=0 while rst high; resp_valid=0, resp_rdata=0, resp_err=0, mem_valid=0, mem_wen=0, mem_addr=0, mem_wdata=0, mem_wmask=0, timeout counter=0.
- States: IDLE, REQ, WAIT, RESP. All outputs except req_ready are registered.
- IDLE: req_ready=1. On req_valid&&req_ready, latch wen, funct3, addr[1:0]; decode.
  - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW.
  - Misaligned: H with addr[0]=1; W with addr[1:0]!=0.
  - Illegal or misaligned -> RESP next cycle with resp_err=1, resp_rdata=0, no memory access.
  - Otherwise -> REQ.
- REQ: mem_valid=1 with stable addr, wen, wdata, wmask until mem_ready. Then -> WAIT, drop mem_valid, clear counter.
- Store lanes, off=addr[1:0]:
  - SB: wdata=wdata[7:0]<<(8*off), wmask=4'b0001<<off.
  - SH: wdata=wdata[15:0]<<(8*off), wmask=4'b0011<<off.
  - SW: wdata unchanged, wmask=4'b1111.
- WAIT: counter increments each cycle.
  - On mem_rsp_valid: loads capture mem_rsp_rdata>>(8*off), truncate to byte/half, then sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes the word. Stores give rdata=0. resp_err=0, -> RESP.
  - If the counter reaches TIMEOUT_CYC before mem_rsp_valid: -> RESP with resp_err=1, rdata=0.
  - A late mem_rsp_valid arriving after a timeout is ignored.
- RESP: resp_valid=1, data held stable until resp_ready. On handshake -> IDLE, resp_valid=0.
- No back-to-back overlap: a new request is accepted only in IDLE, so the earliest next accept is the cycle after the response handshake.
- mem_rsp_valid outside WAIT is ignored. mem_rsp_valid in the same cycle as mem_ready is not permitted (memory contract).
- Latency, zero-wait memory: accept at cycle 0, mem_valid at cycle 1, mem_ready at 1, rsp at 2, resp_valid at 3. Error path: resp_valid at cycle 1.
- rst asserted in any state aborts the op immediately: mem_valid drops asynchronously, and no response is produced for the aborted op.

Decomposition:
- Shared package ysyx_24100005_pkg: funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), FSM state encoding, opcode constants LOAD=7'b0000011 and STORE=7'b0100011 for the core-side decoder.
- One combinational sub-module, ysyx_24100005_lsu_align: store lane shift and wmask generation, plus load extract and extension, given funct3, off and data. The FSM and counter stay in the top LSU.

Test Plan:
- LB, addr=0x80000003, mem word 0x80FF1234 -> mem_addr=0x80000000, mem_wmask=0, resp_rdata=0xFFFFFF80, resp_err=0; resp_valid at cycle 3 with zero-wait memory.
- LHU, addr=0x80000002, word 0xBEEF0011 -> resp_rdata=0x0000BEEF. LH on the same word -> 0xFFFFBEEF.
- SH, addr=0x80000002, wdata=0x1234ABCD -> mem_wdata=0xABCD0000, mem_wmask=4'b1100, mem_wen=1; after rsp, resp_rdata=0.
- LW, addr=0x80000001 -> no mem_valid ever; resp_valid at cycle 1 with resp_err=1, resp_rdata=0. Repeat with funct3=3'b011 (illegal) -> same.
- TIMEOUT_CYC=4, SW, memory acks the request but never responds -> resp_err=1 after 4 WAIT cycles. A mem_rsp_valid injected later is ignored and the next op completes normally.
- Backpressure and reset: mem_ready low for 5 cycles with outputs checked stable; resp_ready low for 3 cycles with resp held. Then rst pulsed while in REQ -> all outputs 0 asynchronously, req_ready=1 once rst deasserts.
